// File: rtl/img_pkg.sv
// Shared types and helpers for the scaled frame-buffer reader.
package img_pkg;

  typedef enum logic {
    SCALE_1X = 1'b0,
    SCALE_2X = 1'b1
  } scale_e;

  localparam int H_ACT_DEF = 640;
  localparam int V_ACT_DEF = 480;

  // Bit replication keeps full-scale codes at 0xFF and zero at 0x00.
  function automatic logic [23:0] rgb565_to_888(input logic [15:0] d);
    return {d[15:11], d[15:13], d[10:5], d[10:9], d[4:0], d[4:2]};
  endfunction

endpackage

// File: rtl/img_addr_gen.sv
// Window decode plus incremental column/line counters producing a registered
// frame-buffer read address; settings are captured once per frame.
module img_addr_gen
  import img_pkg::*;
#(
  parameter int IMG_W  = 320,
  parameter int IMG_H  = 240,
  parameter int ADDR_W = 17,
  parameter int H_ACT  = H_ACT_DEF,
  parameter int V_ACT  = V_ACT_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_de,
  input  logic [9:0]        i_x_pixel,
  input  logic [9:0]        i_y_pixel,
  input  logic              i_scale,
  input  logic              i_mirror,
  input  logic [9:0]        i_x_off,
  input  logic [9:0]        i_y_off,
  output logic [ADDR_W-1:0] o_addr,
  output logic              o_rd_en
);

  localparam int                COL_W     = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam logic [10:0]       IMG_W11   = 11'(IMG_W);
  localparam logic [10:0]       IMG_H11   = 11'(IMG_H);
  localparam logic [10:0]       H_ACT11   = 11'(H_ACT);
  localparam logic [10:0]       V_ACT11   = 11'(V_ACT);
  localparam logic [COL_W-1:0]  COL_LAST  = COL_W'(IMG_W - 1);
  localparam logic [COL_W-1:0]  COL_ONE   = COL_W'(1);
  localparam logic [ADDR_W-1:0] LINE_STEP = ADDR_W'(IMG_W);

  scale_e              r_scale;
  logic                r_mirror;
  logic [9:0]          r_x_off;
  logic [9:0]          r_y_off;
  logic [COL_W-1:0]    r_col;
  logic                r_xsub;
  logic                r_ysub;
  logic                r_line_active;
  logic                r_de_q;
  logic [ADDR_W-1:0]   r_line_base;

  logic                w_frame_start;
  scale_e              w_scale;
  logic                w_mirror;
  logic [9:0]          w_x_off;
  logic [9:0]          w_y_off;
  logic [10:0]         w_x;
  logic [10:0]         w_y;
  logic [10:0]         w_w_eff;
  logic [10:0]         w_h_eff;
  logic [10:0]         w_x_end;
  logic [10:0]         w_y_end;
  logic                w_in_win;
  logic                w_first;
  logic                w_line_end;
  logic                w_ysub_nxt;
  logic                w_xsub;
  logic [COL_W-1:0]    w_col;
  logic [ADDR_W-1:0]   w_line_base;
  logic [ADDR_W-1:0]   w_addr_nxt;

  // The frame-start pixel already belongs to the new frame, so it sees the
  // incoming settings rather than the previously latched ones.
  assign w_frame_start = i_de && (i_x_pixel == 10'd0) && (i_y_pixel == 10'd0);
  assign w_scale       = w_frame_start ? scale_e'(i_scale) : r_scale;
  assign w_mirror      = w_frame_start ? i_mirror : r_mirror;
  assign w_x_off       = w_frame_start ? i_x_off : r_x_off;
  assign w_y_off       = w_frame_start ? i_y_off : r_y_off;
  assign w_line_base   = w_frame_start ? '0 : r_line_base;

  assign w_x     = {1'b0, i_x_pixel};
  assign w_y     = {1'b0, i_y_pixel};
  assign w_w_eff = (w_scale == SCALE_2X) ? (IMG_W11 << 1) : IMG_W11;
  assign w_h_eff = (w_scale == SCALE_2X) ? (IMG_H11 << 1) : IMG_H11;
  assign w_x_end = {1'b0, w_x_off} + w_w_eff;
  assign w_y_end = {1'b0, w_y_off} + w_h_eff;

  assign w_in_win = i_de
                 && (w_x >= {1'b0, w_x_off}) && (w_x < w_x_end)
                 && (w_y >= {1'b0, w_y_off}) && (w_y < w_y_end)
                 && (w_x < H_ACT11) && (w_y < V_ACT11);
  assign w_first  = w_in_win && (w_frame_start || !r_line_active);

  assign w_line_end = r_de_q && !i_de && r_line_active;
  assign w_ysub_nxt = (r_scale == SCALE_2X) ? ~r_ysub : 1'b0;

  always_comb begin
    w_xsub = 1'b0;
    w_col  = r_col;
    if (w_first) begin
      w_col = w_mirror ? COL_LAST : '0;
    end else if (w_in_win) begin
      w_xsub = (w_scale == SCALE_2X) ? ~r_xsub : 1'b0;
      if (!w_xsub) begin
        w_col = w_mirror ? (r_col - COL_ONE) : (r_col + COL_ONE);
      end
    end
  end

  assign w_addr_nxt = w_line_base + ADDR_W'(w_col);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_scale       <= SCALE_1X;
      r_mirror      <= 1'b0;
      r_x_off       <= '0;
      r_y_off       <= '0;
      r_col         <= '0;
      r_xsub        <= 1'b0;
      r_ysub        <= 1'b0;
      r_line_active <= 1'b0;
      r_de_q        <= 1'b0;
      r_line_base   <= '0;
      o_addr        <= '0;
      o_rd_en       <= 1'b0;
    end else begin
      r_de_q  <= i_de;
      o_rd_en <= w_in_win;
      o_addr  <= w_in_win ? w_addr_nxt : '0;
      if (w_frame_start) begin
        r_scale     <= w_scale;
        r_mirror    <= w_mirror;
        r_x_off     <= w_x_off;
        r_y_off     <= w_y_off;
        r_line_base <= '0;
        r_ysub      <= 1'b0;
        r_xsub      <= 1'b0;
      end
      if (w_in_win) begin
        r_col         <= w_col;
        r_xsub        <= w_xsub;
        r_line_active <= 1'b1;
      end
      // Line advance happens in blanking, well before the next line's first pixel.
      if (w_line_end) begin
        r_line_active <= 1'b0;
        r_ysub        <= w_ysub_nxt;
        if (!w_ysub_nxt) begin
          r_line_base <= r_line_base + LINE_STEP;
        end
      end
    end
  end

endmodule

// File: rtl/img_reader_scaled.sv
// Frame-buffer reader: address generation, memory-latency alignment,
// colour-key transparency and RGB565 to RGB888 expansion.
module img_reader_scaled
  import img_pkg::*;
#(
  parameter int IMG_W   = 320,
  parameter int IMG_H   = 240,
  parameter int ADDR_W  = 17,
  parameter int MEM_LAT = 1,
  parameter int H_ACT   = H_ACT_DEF,
  parameter int V_ACT   = V_ACT_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              DE,
  input  logic [9:0]        x_pixel,
  input  logic [9:0]        y_pixel,
  input  logic              scale,
  input  logic              mirror,
  input  logic [9:0]        x_off,
  input  logic [9:0]        y_off,
  input  logic              key_en,
  input  logic [15:0]       key_color,
  output logic [ADDR_W-1:0] addr,
  output logic              rd_en,
  input  logic [15:0]       data,
  output logic [7:0]        r_out,
  output logic [7:0]        g_out,
  output logic [7:0]        b_out,
  output logic              de_out,
  output logic              hit
);

  localparam int L = 2 + MEM_LAT;

  logic [MEM_LAT-1:0] r_win_sr;
  logic [L-2:0]       r_de_sr;

  logic               w_win_d;
  logic               w_de_d;
  logic               w_keyed;
  logic [23:0]        w_rgb;

  img_addr_gen #(
    .IMG_W  (IMG_W),
    .IMG_H  (IMG_H),
    .ADDR_W (ADDR_W),
    .H_ACT  (H_ACT),
    .V_ACT  (V_ACT)
  ) u_addr_gen (
    .clk       (clk),
    .reset     (reset),
    .i_de      (DE),
    .i_x_pixel (x_pixel),
    .i_y_pixel (y_pixel),
    .i_scale   (scale),
    .i_mirror  (mirror),
    .i_x_off   (x_off),
    .i_y_off   (y_off),
    .o_addr    (addr),
    .o_rd_en   (rd_en)
  );

  // Both taps line up with the cycle in which the RAM presents data.
  assign w_win_d = r_win_sr[MEM_LAT-1];
  assign w_de_d  = r_de_sr[L-2];
  assign w_keyed = key_en && (data == key_color);
  assign w_rgb   = rgb565_to_888(data);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_win_sr <= '0;
      r_de_sr  <= '0;
      r_out    <= '0;
      g_out    <= '0;
      b_out    <= '0;
      de_out   <= 1'b0;
      hit      <= 1'b0;
    end else begin
      r_win_sr[0] <= rd_en;
      for (int i = 1; i < MEM_LAT; i++) begin
        r_win_sr[i] <= r_win_sr[i-1];
      end
      r_de_sr[0] <= DE;
      for (int i = 1; i < L - 1; i++) begin
        r_de_sr[i] <= r_de_sr[i-1];
      end
      de_out <= w_de_d;
      if (w_win_d && !w_keyed) begin
        {r_out, g_out, b_out} <= w_rgb;
        hit                   <= 1'b1;
      end else begin
        {r_out, g_out, b_out} <= '0;
        hit                   <= 1'b0;
      end
    end
  end

endmodule
